div_unit: RTL

//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.

---
 rtl/cpu_defs_pkg.sv | 18 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider FSM states and counter sizing.
// Imported by div_unit and div_step.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  function automatic int cnt_w(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem,quo} left, trial subtract, select.
// Ports: rem_i/quo_i/div_i current state, rem_o/quo_o next state.
module div_step
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // The shifted remainder is at most 2*div-1, so one extra bit
  // suffices; diff[WIDTH] set means the trial subtract went negative.
  assign sh    = {rem_i, quo_i[WIDTH-1]};
  assign diff  = sh - {1'b0, div_i};
  assign rem_o = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU), result {rem, quo}.
// Ports: clk, rst, start_i, signed_i, a_i, b_i, hold_i, flush_i ->
// result_o, valid_o, stall_o. Optional: DIV_EARLY_EXIT_EN.
module div_unit
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               valid_o,
  output logic               stall_o
);

  localparam int CW = cnt_w(WIDTH);

  div_state_t state;
  div_state_t state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             early;
  logic             last;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             launch;

  assign neg_a = signed_i & a_i[WIDTH-1];
  assign neg_b = signed_i & b_i[WIDTH-1];
  assign mag_a = neg_a ? (~a_i + 1'b1) : a_i;
  assign mag_b = neg_b ? (~b_i + 1'b1) : b_i;

`ifdef DIV_EARLY_EXIT_EN
  assign early = (b_i == '0) || (mag_a < mag_b);
`else
  assign early = 1'b0;
`endif

  assign last   = (cnt == CW'(WIDTH - 1));
  assign launch = (state == IDLE) && start_i && !flush_i;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem),
    .quo_i(quo),
    .div_i(dvs),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );

  // Divide by zero keeps quotient all ones; the negated |a| remainder
  // reproduces the raw dividend, including the most negative value.
  assign q_fix = dz ? '1 : (sign_q ? (~quo_n + 1'b1) : quo_n);
  assign r_fix = sign_r ? (~rem_n + 1'b1) : rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    stall_o = start_i && (state != DONE) && !flush_i;
    valid_o = (state == DONE) && !flush_i;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start_i) state_n = early ? DONE : BUSY;
        BUSY: if (last) state_n = DONE;
        DONE: if (!hold_i) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dz       <= 1'b0;
      result_o <= '0;
    end else begin
      if (launch) begin
        cnt    <= '0;
        rem    <= '0;
        quo    <= mag_a;
        dvs    <= mag_b;
        sign_q <= neg_a ^ neg_b;
        sign_r <= neg_a;
        dz     <= (b_i == '0);
        if (early) begin
          result_o <= {a_i, {WIDTH{b_i == '0}}};
        end
      end
      if ((state == BUSY) && !flush_i) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          result_o <= {r_fix, q_fix};
        end
      end
    end
  end

endmodule
